// File: rtl/disp2_pkg.sv
// Shared definitions for the disp2 two-lane device: default widths, lane ids
// and a small helper for round-robin lane selection.
package disp2_pkg;

  localparam int DISP2_DATA_W    = 8;
  localparam int DISP2_MAX_BURST = 4;

  // Lane identifiers; the value doubles as the src_out tag bit.
  typedef enum logic {
    LANE1 = 1'b0,
    LANE2 = 1'b1
  } lane_t;

  // The lane that is not l.
  function automatic lane_t lane_other(input lane_t l);
    return (l == LANE1) ? LANE2 : LANE1;
  endfunction

endpackage

// File: rtl/disp2_skid_q.sv
// Two-entry FIFO holding merged bytes with their lane tag. Head is shown
// combinationally so the output stays stable while the consumer stalls.
module disp2_skid_q #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  // A pop frees a slot in the same cycle, so push into a full queue is
  // accepted only when it coincides with a pop.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // Storage, pointers and occupancy; contents clear on reset so the head
  // reads as zero while the queue is empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head = mem[rd_ptr];
  assign occ  = count;

endmodule

// File: rtl/disp2_drain_arbiter.sv
// Drains the two disp2 lane FIFOs onto one tagged byte stream. Reads are
// issued combinationally against the current queue state, the lane byte is
// captured one cycle later into a 2-entry skid queue, and per-lane counters
// track bytes accepted downstream.
module disp2_drain_arbiter
  import disp2_pkg::*;
#(
  parameter int DATA_W    = DISP2_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = DISP2_MAX_BURST,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] out1,
  input  logic [DATA_W-1:0] out2,
  input  logic              empty_f1,
  input  logic              empty_f2,
  input  logic              almost_full_f1,
  input  logic              almost_full_f2,
  output logic              read_f1,
  output logic              read_f2,
  input  logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              src_out,
  output logic [CNT_W-1:0]  cnt_f1,
  output logic [CNT_W-1:0]  cnt_f2
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  // The capture stage assumes lane data is valid exactly one cycle after the
  // read pulse.
  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("disp2_drain_arbiter supports RD_LAT = 1 only");
  end

  logic               inflight;
  lane_t              inflight_lane;
  lane_t              last_grant;
  lane_t              other_lane;
  lane_t              grant_lane;
  logic               grant_valid;
  logic [BURST_W-1:0] burst_cnt;
  logic               elig1;
  logic               elig2;
  logic               other_elig;
  logic               burst_hit;
  logic               capacity_ok;
  logic [2:0]         pending;
  logic [1:0]         occ;
  logic [DATA_W:0]    head;
  logic [DATA_W:0]    push_data;
  logic               pop;
  logic [1:0][CNT_W-1:0] cnt_bus;

  assign elig1      = !empty_f1;
  assign elig2      = !empty_f2;
  assign other_lane = lane_other(last_grant);
  assign other_elig = (other_lane == LANE1) ? elig1 : elig2;
  assign burst_hit  = (burst_cnt >= BURST_W'(MAX_BURST)) && other_elig;

  // Bytes already committed to the queue (stored or in flight) after this
  // cycle's pop; a new read is allowed only if it will still fit.
  assign pop         = valid_out && ready_out;
  assign pending     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign capacity_ok = (pending < 3'd2);

  // Grant selection: burst limit first, then a single eligible lane, then
  // urgency of a lone almost-full lane, otherwise alternate lanes.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = LANE1;
    if (reset && capacity_ok && (elig1 || elig2)) begin
      grant_valid = 1'b1;
      if (burst_hit) begin
        grant_lane = other_lane;
      end else if (!elig2) begin
        grant_lane = LANE1;
      end else if (!elig1) begin
        grant_lane = LANE2;
      end else if (almost_full_f1 && !almost_full_f2) begin
        grant_lane = LANE1;
      end else if (almost_full_f2 && !almost_full_f1) begin
        grant_lane = LANE2;
      end else begin
        grant_lane = other_lane;
      end
    end
  end

  assign read_f1 = grant_valid && (grant_lane == LANE1);
  assign read_f2 = grant_valid && (grant_lane == LANE2);

  // Arbitration history: in-flight read, last winner and its run length
  // (saturating, since only the limit crossing matters).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight      <= 1'b0;
      inflight_lane <= LANE1;
      last_grant    <= LANE2;
      burst_cnt     <= '0;
    end else begin
      inflight      <= grant_valid;
      inflight_lane <= grant_lane;
      if (grant_valid) begin
        last_grant <= grant_lane;
        if (grant_lane != last_grant) begin
          burst_cnt <= BURST_W'(1);
        end else if (burst_cnt < BURST_W'(MAX_BURST)) begin
          burst_cnt <= burst_cnt + BURST_W'(1);
        end
      end
    end
  end

  // Byte returned by the lane read last cycle, tagged with its lane.
  assign push_data = {inflight_lane, (inflight_lane == LANE2) ? out2 : out1};

  disp2_skid_q #(
    .W (DATA_W + 1)
  ) u_skid_q (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign valid_out = (occ != 2'd0);
  assign data_out  = head[DATA_W-1:0];
  assign src_out   = head[DATA_W];

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam logic LANE_TAG = (gi == 0) ? 1'b0 : 1'b1;
    logic [CNT_W-1:0] count;

    // Bytes from this lane accepted downstream, wrapping naturally.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        count <= '0;
      end else if (pop && (src_out == LANE_TAG)) begin
        count <= count + CNT_W'(1);
      end
    end

    assign cnt_bus[gi] = count;
  end

  assign cnt_f1 = cnt_bus[0];
  assign cnt_f2 = cnt_bus[1];

endmodule

// File: tb/tb_disp2_drain_arbiter.sv
// Bench for disp2_drain_arbiter: a reset-state decision table, directed
// multi-cycle sequences and a randomized run, all checked against a
// transaction-level model (lane queues, grant history, output scoreboard).
module tb_disp2_drain_arbiter;
  import disp2_pkg::*;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  out1 = 8'h00;
  logic [7:0]  out2 = 8'h00;
  logic        empty_f1 = 1'b1;
  logic        empty_f2 = 1'b1;
  logic        almost_full_f1 = 1'b0;
  logic        almost_full_f2 = 1'b0;
  logic        ready_out = 1'b1;
  logic        read_f1;
  logic        read_f2;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        src_out;
  logic [15:0] cnt_f1;
  logic [15:0] cnt_f2;

  disp2_drain_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .out1           (out1),
    .out2           (out2),
    .empty_f1       (empty_f1),
    .empty_f2       (empty_f2),
    .almost_full_f1 (almost_full_f1),
    .almost_full_f2 (almost_full_f2),
    .read_f1        (read_f1),
    .read_f2        (read_f2),
    .ready_out      (ready_out),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .src_out        (src_out),
    .cnt_f1         (cnt_f1),
    .cnt_f2         (cnt_f2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int         lane;
    logic [7:0] data;
    int         cyc;
  } item_t;

  item_t      sb[$];      // granted bytes not yet accepted downstream
  logic [7:0] q1[$];      // upstream lane FIFO contents
  logic [7:0] q2[$];
  int         hist[$];    // lane of every grant since reset
  int         acc_src[$]; // lane of every accepted byte since reset
  int         exp_cnt[2];
  int         cyc;
  logic       pend_r1;
  logic       pend_r2;

  // Grant rule from the lane situation and the grant history.
  function automatic int model_grant(input bit e1, input bit e2, input bit a1,
                                     input bit a2, input bit cap);
    bit el[2];
    int last;
    int run;
    int other;
    el[0] = e1;
    el[1] = e2;
    if (!cap || (!e1 && !e2)) return -1;
    last = (hist.size() == 0) ? 1 : hist[hist.size()-1];
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && run < MB; i--) begin
      if (hist[i] != last) break;
      run++;
    end
    other = 1 - last;
    if (run >= MB && el[other]) return other;
    if (!e2) return 0;
    if (!e1) return 1;
    if (a1 != a2) return a1 ? 0 : 1;
    return other;
  endfunction

  // Compare one cycle of DUT outputs with the model and advance the model.
  task automatic observe();
    bit    exp_valid;
    bit    pop_now;
    bit    cap;
    int    g;
    item_t it;
    check("cnt_f1", cnt_f1, exp_cnt[0]);
    check("cnt_f2", cnt_f2, exp_cnt[1]);
    exp_valid = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
    check("valid_out", valid_out, exp_valid);
    if (exp_valid) begin
      check("data_out", data_out, sb[0].data);
      check("src_out", src_out, sb[0].lane);
    end
    pop_now = exp_valid && ready_out;
    cap = (sb.size() - int'(pop_now)) < 2;
    g = model_grant(q1.size() != 0, q2.size() != 0, almost_full_f1, almost_full_f2, cap);
    check("read_f1", read_f1, g == 0);
    check("read_f2", read_f2, g == 1);
    if (g >= 0) begin
      sb.push_back('{lane: g, data: (g == 0) ? q1[0] : q2[0], cyc: cyc});
      hist.push_back(g);
    end
    if (pop_now) begin
      it = sb.pop_front();
      exp_cnt[it.lane] = exp_cnt[it.lane] + 1;
      acc_src.push_back(it.lane);
      $display("accept cyc=%0d lane=%0d data=0x%02h", cyc, it.lane + 1, it.data);
    end
    pend_r1 = read_f1;
    pend_r2 = read_f2;
  endtask

  // One clock: settle inputs, check at the falling edge, then let the lane
  // FIFOs react to the read strobes just after the rising edge.
  task automatic tick();
    empty_f1 = (q1.size() == 0);
    empty_f2 = (q2.size() == 0);
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    if (pend_r1 && q1.size() > 0) out1 = q1.pop_front();
    if (pend_r2 && q2.size() > 0) out2 = q2.pop_front();
    empty_f1 = (q1.size() == 0);
    empty_f2 = (q2.size() == 0);
  endtask

  task automatic drain(input string name, input int limit);
    int k = 0;
    while ((sb.size() > 0 || q1.size() > 0 || q2.size() > 0) && k < limit) begin
      tick();
      k++;
    end
    check({name, "_drained"}, sb.size() + q1.size() + q2.size(), 0);
  endtask

  // Asynchronous reset from the current point; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_read_f1", read_f1, 0);
    check("rst_read_f2", read_f2, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_src", src_out, 0);
    check("rst_cnt_f1", cnt_f1, 0);
    check("rst_cnt_f2", cnt_f2, 0);
    sb.delete();
    hist.delete();
    acc_src.delete();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    pend_r1 = 1'b0;
    pend_r2 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_read", {read_f1, read_f2}, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  // ---------------- reset-state decision table ----------------
  typedef struct {
    logic e1, e2, a1, a2;
    logic r1, r2;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[4];
    logic [7:0] b;

    vecs[0] = '{e1: 1, e2: 1, a1: 0, a2: 0, r1: 0, r2: 0};
    vecs[1] = '{e1: 0, e2: 1, a1: 0, a2: 0, r1: 1, r2: 0};
    vecs[2] = '{e1: 1, e2: 0, a1: 0, a2: 0, r1: 0, r2: 1};
    vecs[3] = '{e1: 0, e2: 0, a1: 0, a2: 0, r1: 1, r2: 0};
    vecs[4] = '{e1: 0, e2: 0, a1: 0, a2: 1, r1: 0, r2: 1};
    vecs[5] = '{e1: 0, e2: 0, a1: 1, a2: 0, r1: 1, r2: 0};
    vecs[6] = '{e1: 0, e2: 0, a1: 1, a2: 1, r1: 1, r2: 0};
    vecs[7] = '{e1: 1, e2: 0, a1: 1, a2: 0, r1: 0, r2: 1};
    rr_exp = '{0, 1, 0, 1};
    pend_r1 = 1'b0;
    pend_r2 = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;

    #2 reset = 1'b0;
    // Released between clock edges, so the arbiter sits in its reset state.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      empty_f1 = vecs[i].e1;
      empty_f2 = vecs[i].e2;
      almost_full_f1 = vecs[i].a1;
      almost_full_f2 = vecs[i].a2;
      reset = 1'b1;
      #1;
      check($sformatf("tbl%0d_read_f1", i), read_f1, vecs[i].r1);
      check($sformatf("tbl%0d_read_f2", i), read_f2, vecs[i].r2);
      check($sformatf("tbl%0d_valid", i), valid_out, 0);
      reset = 1'b0;
      #1;
    end
    empty_f1 = 1'b1;
    empty_f2 = 1'b1;
    almost_full_f1 = 1'b0;
    almost_full_f2 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;

    // Idle: nothing to read.
    repeat (5) tick();
    check("idle_reads", hist.size(), 0);

    // Single lane stream.
    q1.push_back(8'h11);
    q1.push_back(8'h22);
    q1.push_back(8'h33);
    drain("single", 30);
    check("single_reads", hist.size(), 3);
    check("single_cnt_f1", cnt_f1, 3);
    check("single_cnt_f2", cnt_f2, 0);

    // Round-robin with both lanes busy.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q1.push_back(8'hA0 + 8'(i));
      q2.push_back(8'hB0 + 8'(i));
    end
    drain("rr", 40);
    for (int i = 0; i < 4; i++) check($sformatf("rr_src%0d", i), acc_src[i], rr_exp[i]);

    // Lane 2 urgent, limited to bursts of MAX_BURST.
    do_reset();
    almost_full_f2 = 1'b1;
    for (int i = 0; i < 12; i++) q2.push_back(8'h40 + 8'(i));
    for (int i = 0; i < 3; i++) q1.push_back(8'h70 + 8'(i));
    drain("urgent", 60);
    check("urgent_grants", hist.size(), 15);
    for (int i = 0; i < 15 && i < hist.size(); i++)
      check($sformatf("urgent_grant%0d", i), hist[i], (i % 5 == 4) ? 0 : 1);
    almost_full_f2 = 1'b0;

    // Backpressure: two reads fill the queue, then hold.
    do_reset();
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q1.push_back(8'hC0 + 8'(i));
      q2.push_back(8'hD0 + 8'(i));
    end
    repeat (5) tick();
    check("bp_reads", hist.size(), 2);
    ready_out = 1'b1;
    drain("bp", 40);
    check("bp_accepted", acc_src.size(), 8);
    check("bp_cnt_f1", cnt_f1, 4);
    check("bp_cnt_f2", cnt_f2, 4);

    // Reset mid-stream right after a lane-1 grant with bytes queued.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q1.push_back(8'h51 + 8'(i));
      q2.push_back(8'h61 + 8'(i));
    end
    begin
      int k = 0;
      do begin
        tick();
        k++;
      end while (!(hist.size() > 2 && hist[hist.size()-1] == 0 && sb.size() >= 2) && k < 20);
      check("mid_setup", k < 20, 1);
    end
    do_reset();
    tick();
    check("mid_first_grant_l1", read_f1 === 1'b0 && hist.size() == 1 && hist[0] == 0, 1);
    drain("mid", 40);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (q1.size() < 8 && $urandom_range(1, 0) == 1) q1.push_back(8'($urandom));
      if (q2.size() < 8 && $urandom_range(1, 0) == 1) q2.push_back(8'($urandom));
      almost_full_f1 = ($urandom_range(3, 0) == 0);
      almost_full_f2 = ($urandom_range(3, 0) == 0);
      ready_out = ($urandom_range(3, 0) != 0);
      tick();
    end
    almost_full_f1 = 1'b0;
    almost_full_f2 = 1'b0;
    ready_out = 1'b1;
    drain("rand", 100);
    check("rand_cnt_f1", cnt_f1, exp_cnt[0]);
    check("rand_cnt_f2", cnt_f2, exp_cnt[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
